// File: rtl/pio_in_edge_capture_if.sv
// pio_in_edge_capture_if: Avalon-MM slave bus (readLatency=1, no waitrequest) for the input PIO.
interface pio_in_edge_capture_if;
    logic [1:0] address;
    logic chipselect;
    logic write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: input PIO with per-bit sticky edge capture and masked level irq.
// Define PIO_IN_SYNC2_EN for a two-flop synchroniser on in_port; default is a single input register.
module pio_in_edge_capture #(
    parameter int WIDTH = 8,
    parameter int EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
    input  logic clk,
    input  logic reset_n,
    pio_in_edge_capture_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic irq
);
`ifdef PIO_IN_SYNC2_EN
    localparam int S = 2;
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) meta <= '0;
        else meta <= in_port;
`else
    localparam int S = 1;
    logic [WIDTH-1:0] meta;
    assign meta = in_port;
`endif
    // Capture stays off until data_s and d1 both hold post-reset samples.
    localparam logic [1:0] ARM = 2'(S + 1);
    logic [WIDTH-1:0] data_s, d1, edge_det, edge_capture, irq_mask;
    logic [1:0] arm_cnt;
    logic armed, wr, unused_wd;
    logic [31:0] rd_mux;
    assign armed = arm_cnt == ARM;
    assign wr = bus.chipselect && !bus.write_n;
    assign unused_wd = ^bus.writedata;
    assign edge_det = EDGE_TYPE == 0 ? data_s & ~d1 : EDGE_TYPE == 1 ? ~data_s & d1 : data_s ^ d1;
    assign irq = |(edge_capture & irq_mask);
    always_comb begin
        rd_mux = '0;
        rd_mux[WIDTH-1:0] = bus.address == 2'd0 ? data_s :
                            bus.address == 2'd2 ? irq_mask :
                            bus.address == 2'd3 ? edge_capture : '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            data_s       <= '0;
            d1           <= '0;
            arm_cnt      <= '0;
            irq_mask     <= RESET_MASK;
            edge_capture <= '0;
            bus.readdata <= '0;
        end else begin
            data_s <= meta;
            d1     <= data_s;
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
            if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
            // A new edge overrides a same-cycle W1C on that bit.
            edge_capture <= (edge_capture & ~(wr && bus.address == 2'd3 ? bus.writedata[WIDTH-1:0] : '0))
                          | (armed ? edge_det : '0);
            bus.readdata <= rd_mux;
        end
endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb_pio_in_edge_capture: directed checks of rising, falling and any-edge instances on a shared bus.
module tb_pio_in_edge_capture;
`ifdef PIO_IN_SYNC2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    logic clk, reset_n;
    logic [1:0] address;
    logic chipselect, write_n;
    logic [31:0] writedata;
    logic [7:0] in_port;
    logic [2:0] irq_v;
    logic [31:0] rdv [3];
    int n_checks = 0;
    int n_fail = 0;

    pio_in_edge_capture_if b[3] ();

    // Instance g captures EDGE_TYPE g: 0 rising, 1 falling, 2 any.
    for (genvar g = 0; g < 3; g++) begin : gd
        assign b[g].address    = address;
        assign b[g].chipselect = chipselect;
        assign b[g].write_n    = write_n;
        assign b[g].writedata  = writedata;
        assign rdv[g]          = b[g].readdata;
        pio_in_edge_capture #(.WIDTH(8), .EDGE_TYPE(g)) dut (
            .clk(clk), .reset_n(reset_n), .bus(b[g]), .in_port(in_port), .irq(irq_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        repeat (S + 2) tick;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        tick;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = 8'hFF;
        address = 2'd0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        repeat (3) tick;
        check("rst_rdata", rdv[0], 32'h0);
        check("rst_irq", {29'b0, irq_v}, 32'h0);
        reset_n = 1'b1;
        repeat (10) tick;
        rd(3);
        check("held_cap_rise", rdv[0], 32'h0);
        check("held_cap_fall", rdv[1], 32'h0);
        check("held_cap_any", rdv[2], 32'h0);
        check("held_irq", {29'b0, irq_v}, 32'h0);
        rd(0);
        check("data_read", rdv[0], 32'h0000_00FF);
        wr(0, 32'h55);
        rd(0);
        check("data_ro", rdv[0], 32'h0000_00FF);
        rd(1);
        check("reserved", rdv[0], 32'h0);
        rd(2);
        check("mask_rst", rdv[0], 32'h0);

        in_port = 8'h00;
        settle;
        rd(3);
        check("fall_all_rise", rdv[0], 32'h0);
        check("fall_all_fall", rdv[1], 32'hFF);
        check("fall_all_any", rdv[2], 32'hFF);
        wr(3, 32'hFF);
        rd(3);
        check("w1c_all", rdv[1], 32'h0);

        wr(2, 32'h01);
        rd(2);
        check("mask_wr", rdv[0], 32'h01);
        in_port = 8'h01;
        repeat (S) tick;
        check("irq_early", irq_v[0], 1'b0);
        tick;
        check("irq_latency", irq_v[0], 1'b1);
        rd(3);
        check("cap_bit0", rdv[0], 32'h01);
        wr(3, 32'h01);
        check("irq_after_w1c", irq_v[0], 1'b0);

        in_port = 8'h09;
        settle;
        in_port = 8'h01;
        settle;
        rd(3);
        check("cap_bit3", rdv[0], 32'h08);
        check("irq_masked", irq_v[0], 1'b0);
        wr(2, 32'h08);
        check("irq_unmask", irq_v[0], 1'b1);
        wr(3, 32'hFF);
        check("irq_clear3", irq_v[0], 1'b0);

        wr(2, 32'h01);
        in_port = 8'h00;
        settle;
        wr(3, 32'hFF);
        in_port = 8'h01;
        repeat (S) tick;
        wr(3, 32'h01);
        check("collide_irq", irq_v[0], 1'b1);
        rd(3);
        check("collide_cap", rdv[0], 32'h01);
        wr(3, 32'hFF);

        in_port = 8'h21;
        tick;
        in_port = 8'h01;
        repeat (S) tick;
        rd(3);
        check("pulse_rise_mid", rdv[0], 32'h20);
        check("pulse_fall_mid", rdv[1], 32'h0);
        check("pulse_any_mid", rdv[2], 32'h20);
        settle;
        rd(3);
        check("pulse_rise", rdv[0], 32'h20);
        check("pulse_fall", rdv[1], 32'h20);
        check("pulse_any", rdv[2], 32'h20);

        wr(3, 32'hFF);
        in_port = 8'h00;
        settle;
        wr(3, 32'hFF);
        in_port = 8'hA5;
        settle;
        wr(2, 32'hFF);
        rd(3);
        check("pre_rst_cap", rdv[0], 32'hA5);
        check("pre_rst_irq", irq_v[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {29'b0, irq_v}, 32'h0);
        check("async_rst_rdata", rdv[0], 32'h0);
        in_port = 8'hFF;
        repeat (2) tick;
        reset_n = 1'b1;
        repeat (6) tick;
        rd(3);
        check("arm_cap_rise", rdv[0], 32'h0);
        check("arm_cap_any", rdv[2], 32'h0);
        rd(2);
        check("mask_after_rst", rdv[0], 32'h0);
        check("irq_after_rst", irq_v[0], 1'b0);
        in_port = 8'h7F;
        settle;
        in_port = 8'hFF;
        settle;
        rd(3);
        check("rearm_rise", rdv[0], 32'h80);
        check("rearm_fall", rdv[1], 32'h80);
        check("rearm_any", rdv[2], 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
- Avalon-MM slave input PIO for switches and keys; the read-side counterpart of the board's LED output PIOs.
- Synchronises an external input bus and exposes it as a readable data register.
- Detects edges per bit into a sticky edge-capture register and raises a level interrupt for unmasked captured bits.
- Sits between the board input pins and the Qsys interconnect, one instance per input group.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 0, captured edge: 0 = rising, 1 = falling, 2 = any.
- RESET_MASK, 0, reset value of the interrupt mask register (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select, word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: all sync/delay flops = 0, edge_capture = 0, irq_mask = RESET_MASK, readdata = 0, irq = 0, arm counter = 0. All asynchronous on reset_n low.
- Input path: in_port passes through S sample stages (S=1, or 2 with the optional feature) to give data_s. d1 is data_s delayed one clock.
- Edge detection per bit:
  - rising: data_s & ~d1
  - falling: ~data_s & d1
  - any: data_s ^ d1
- Arming: after reset release, a counter suppresses capture for the first S+1 clocks. This prevents a held-high input from producing a spurious edge. Once armed, the block stays armed until the next reset.
- Register map (read all, write where noted):
  - 0: data, read-only = data_s; writes are ignored.
  - 1: reserved; reads 0; writes are ignored.
  - 2: irq_mask, R/W, bits [WIDTH-1:0].
  - 3: edge_capture, R/W1C; writing 1 to a bit clears it, writing 0 leaves it unchanged.
- Capture: bit n sets on the clock after edge n is detected while armed. It stays set until cleared.
- Set/clear collision: if the set and a W1C on the same bit occur in the same cycle, set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), combinational from registers. It deasserts the cycle after the last unmasked bit is cleared, or after the mask is written to 0.
- Read: readdata is registered every clock from the mux of the current address, which gives read latency 1. The slave is declared readLatency=1 and has no waitrequest. Bits above WIDTH always read 0.
- Latency, in_port change to capture bit set:
  - S=1: in_port changes before clock edge k; capture bit is set at edge k+1; irq can assert after edge k+1.
  - S=2: the same sequence completes at edge k+2.
- Glitches: a pulse shorter than one clock may be missed. A pulse of one or more full clocks is always captured. Back-to-back edges on a bit already set are absorbed, with no count kept.
- Reset mid-operation: all state clears immediately, including pending captures; the arming suppression restarts.

Optional Feature:
- Macro: PIO_IN_SYNC2_EN.
- Defined: S=2, a two-flop metastability synchroniser on in_port. Latency rises by one clock and the arming window is 3 clocks.
- Undefined: S=1, a single input register for inputs already synchronous to clk. Arming window is 2 clocks.
- The register map and irq semantics are identical in both builds.

Test Plan:
- Reset with in_port=8'hFF held (EDGE_TYPE=0), wait 10 clocks -> edge_capture reads 0, irq=0; read address 0 returns 32'h000000FF one clock after the address is presented.
- Write irq_mask=8'h01; take in_port bit0 0→1 -> edge_capture=8'h01 and irq=1 at edge k+1 (S=1) or k+2 (PIO_IN_SYNC2_EN); write 8'h01 to address 3 -> capture=0, irq=0 the next cycle.
- Toggle bit3 (mask bit3=0) -> edge_capture=8'h08, irq stays 0; then write mask=8'h08 -> irq=1 the next cycle.
- Hold a bit0 W1C write on the exact cycle a new bit0 edge sets capture -> bit0 reads 1 afterwards and irq stays asserted.
- EDGE_TYPE=2 with a one-clock-wide high pulse on bit5 -> edge_capture=8'h20 (both edges, a single sticky bit); EDGE_TYPE=1 with the same pulse -> set from the falling edge only.
- Assert reset_n low mid-way with capture=8'hA5 and mask=8'hFF -> capture=0, mask=RESET_MASK, irq=0 immediately; edges inside the arming window after release are ignored.
